// File: rtl/bus_fabric.sv
// Single-master to N-slave interconnect for the picorv32 native bus.
// Decodes by base/mask, guards firmware-only regions, times out slow slaves and keeps sticky error status.
module bus_fabric #(
    parameter int                       NUM_SLAVES     = 8,
    parameter logic [32*NUM_SLAVES-1:0] SLV_BASE       = {NUM_SLAVES{32'h0}},
    parameter logic [32*NUM_SLAVES-1:0] SLV_MASK       = {NUM_SLAVES{32'hc0000000}},
    parameter logic [NUM_SLAVES-1:0]    FW_ONLY        = {NUM_SLAVES{1'b0}},
    parameter int                       TIMEOUT_CYCLES = 255,
    parameter int                       TIMEOUT_W      = 8,
    parameter logic [31:0]              ERROR_RDATA    = 32'h0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       cpu_valid,
    input  logic [31:0]                cpu_addr,
    input  logic [3:0]                 cpu_wstrb,
    input  logic [31:0]                cpu_wdata,
    output logic                       cpu_ready,
    output logic [31:0]                cpu_rdata,
    input  logic                       fw_app_mode,
    input  logic                       force_trap,
    output logic [NUM_SLAVES-1:0]      slv_cs,
    output logic [3:0]                 slv_we,
    output logic [31:0]                slv_address,
    output logic [31:0]                slv_write_data,
    input  logic [32*NUM_SLAVES-1:0]   slv_read_data,
    input  logic [NUM_SLAVES-1:0]      slv_ready,
    input  logic                       err_clear,
    output logic                       err_unmapped,
    output logic                       err_violation,
    output logic                       err_timeout,
    output logic [31:0]                err_addr,
    output logic [1:0]                 dbg_state
);

    localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

    // Handshake: the request is taken on the first edge where cpu_valid is high in IDLE; cpu_ready
    // pulses for exactly one cycle with cpu_rdata valid, and the master must drop cpu_valid before IDLE.
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [IDX_W-1:0]       r_idx;
    logic [TIMEOUT_W-1:0]   r_cnt;
    logic                   r_ready;
    logic [31:0]            r_rdata;
    logic [3:0]             r_we;
    logic [31:0]            r_address;
    logic [31:0]            r_wdata;
    logic                   r_err_unmapped;
    logic                   r_err_violation;
    logic                   r_err_timeout;
    logic [31:0]            r_err_addr;

    logic                   w_hit;
    logic [IDX_W-1:0]       w_hit_idx;
    logic                   w_violation;
    logic                   w_reject;
    logic                   w_sel_ready;
    logic                   w_cnt_last;
    logic [31:0]            w_rd [NUM_SLAVES];

    // Descending scan so the lowest matching index is the one left standing.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_idx = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((cpu_addr & SLV_MASK[32*i +: 32]) == SLV_BASE[32*i +: 32]) begin
                w_hit     = 1'b1;
                w_hit_idx = IDX_W'(i);
            end
        end
    end

    for (genvar g = 0; g < NUM_SLAVES; g++) begin : g_rd
        assign w_rd[g] = slv_read_data[32*g +: 32];
    end

    assign w_violation = w_hit && FW_ONLY[w_hit_idx] && fw_app_mode;
    assign w_reject    = force_trap || !w_hit || w_violation;
    assign w_sel_ready = slv_ready[r_idx];
    assign w_cnt_last  = (r_cnt == TIMEOUT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (cpu_valid) w_next = w_reject ? S_RESP : S_ACCESS;
            S_ACCESS: if (w_sel_ready || w_cnt_last) w_next = S_RESP;
            S_RESP:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        slv_cs = '0;
        if (r_state == S_ACCESS) slv_cs[r_idx] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idx           <= '0;
            r_cnt           <= '0;
            r_ready         <= 1'b0;
            r_rdata         <= '0;
            r_we            <= '0;
            r_address       <= '0;
            r_wdata         <= '0;
            r_err_unmapped  <= 1'b0;
            r_err_violation <= 1'b0;
            r_err_timeout   <= 1'b0;
            r_err_addr      <= '0;
        end else begin
            r_ready <= (w_next == S_RESP);
            // Clear first so a coincident set, assigned later, takes precedence.
            if (err_clear) begin
                r_err_unmapped  <= 1'b0;
                r_err_violation <= 1'b0;
                r_err_timeout   <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if (cpu_valid) begin
                        r_address <= cpu_addr;
                        r_we      <= cpu_wstrb;
                        r_wdata   <= cpu_wdata;
                        r_idx     <= w_hit_idx;
                        r_cnt     <= '0;
                        if (force_trap) begin
                            r_rdata <= ERROR_RDATA;
                        end else if (!w_hit) begin
                            r_rdata        <= ERROR_RDATA;
                            r_err_unmapped <= 1'b1;
                            r_err_addr     <= cpu_addr;
                        end else if (w_violation) begin
                            r_rdata         <= ERROR_RDATA;
                            r_err_violation <= 1'b1;
                            r_err_addr      <= cpu_addr;
                        end
                    end
                end
                S_ACCESS: begin
                    if (w_sel_ready) begin
                        r_rdata <= w_rd[r_idx];
                    end else if (w_cnt_last) begin
                        r_rdata       <= ERROR_RDATA;
                        r_err_timeout <= 1'b1;
                        r_err_addr    <= r_address;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign cpu_ready      = r_ready;
    assign cpu_rdata      = r_rdata;
    assign slv_we         = r_we;
    assign slv_address    = r_address;
    assign slv_write_data = r_wdata;
    assign err_unmapped   = r_err_unmapped;
    assign err_violation  = r_err_violation;
    assign err_timeout    = r_err_timeout;
    assign err_addr       = r_err_addr;
    assign dbg_state      = r_state;

endmodule

// File: doc/bus_fabric.md
Name: bus_fabric

Overview:
- Parametrised successor to the fixed CPU memory decoder: a single-master (picorv32 native bus) to N-slave interconnect.
- Slave regions come from base/mask parameter vectors rather than hardwired prefixes.
- Adds what the fixed decoder lacks: per-transaction FSM with latched request, slave-response timeout, firmware-only region protection, and sticky error status with a captured fault address.
- Sits between the CPU and all memory/MMIO cores in the top level.

Parameters:
- NUM_SLAVES, 8, number of slave ports (1..16).
- SLV_BASE, {NUM_SLAVES{32'h0}}, flattened 32-bit base per slave; slave i at bits [32*i+31:32*i].
- SLV_MASK, {NUM_SLAVES{32'hc0000000}}, flattened 32-bit decode mask per slave.
- FW_ONLY, {NUM_SLAVES{1'b0}}, bit i set: slave i is accessible only when fw_app_mode=0.
- TIMEOUT_CYCLES, 255, maximum ACCESS cycles before an error response (1..2^TIMEOUT_W-1).
- TIMEOUT_W, 8, timeout counter width.
- ERROR_RDATA, 32'h0, read data returned on any error response (0 = illegal instruction, traps on fetch).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cpu_valid  in  1  request valid
- cpu_addr  in  32  request address
- cpu_wstrb  in  4  byte write strobes (0 = read)
- cpu_wdata  in  32  write data
- cpu_ready  out  1  response strobe, registered
- cpu_rdata  out  32  response data, registered
- fw_app_mode  in  1  1 = application mode
- force_trap  in  1  answer the next accepted request with ERROR_RDATA
- slv_cs  out  NUM_SLAVES  one-hot chip select
- slv_we  out  4  latched strobes (valid while any cs high)
- slv_address  out  32  latched cpu_addr
- slv_write_data  out  32  latched cpu_wdata
- slv_read_data  in  32*NUM_SLAVES  flattened slave read data
- slv_ready  in  NUM_SLAVES  slave ready
- err_clear  in  1  clear sticky error flags
- err_unmapped  out  1  sticky: access hit no slave
- err_violation  out  1  sticky: FW_ONLY slave accessed in app mode
- err_timeout  out  1  sticky: slave failed to respond in time
- err_addr  out  32  address of the most recent error

Behaviour:
- Decode: slave i hits when (cpu_addr & SLV_MASK_i) == SLV_BASE_i. If several hit, the lowest index wins.
- Reset: asynchronous, to state IDLE. All outputs 0: cpu_ready, cpu_rdata, slv_cs, slv_we, slv_address, slv_write_data, err_*, timeout counter. Reset mid-access drops slv_cs immediately and discards the transaction.
- FSM states: IDLE, ACCESS, RESP.
- IDLE, on cpu_valid:
  - Latch addr, wstrb and wdata into the slv_* registers, the selected index, and zero the counter.
  - Priority: force_trap, then unmapped, then violation (FW_ONLY_i & fw_app_mode), then normal.
  - Error cases: cpu_rdata <= ERROR_RDATA and go to RESP; no slv_cs is ever asserted.
  - Normal case: go to ACCESS.
- ACCESS:
  - slv_cs[idx] = 1, combinational from the registered state and index.
  - If slv_ready[idx]: cpu_rdata <= slv_read_data[idx], go to RESP.
  - Else if counter == TIMEOUT_CYCLES-1: cpu_rdata <= ERROR_RDATA, set err_timeout, go to RESP.
  - Else increment the counter.
  - cpu_valid and address changes during ACCESS are ignored.
- RESP: cpu_ready = 1 for exactly one cycle, then go to IDLE. No request is accepted in RESP.
- Latency, with valid first high at cycle t:
  - Error and trap responses: cpu_ready at t+1.
  - A slave with ready in its first cs cycle: cpu_ready at t+2.
  - A slave with k wait cycles: cpu_ready at t+2+k.
  - Timeout: cpu_ready at t+1+TIMEOUT_CYCLES.
- Error flags:
  - Each error sets its flag and loads err_addr on entry to RESP.
  - force_trap sets no flag.
  - err_clear clears all flags. If a set and err_clear occur in the same cycle, the set wins.
  - err_addr is not cleared by err_clear.
- Writes on error paths are dropped; no slave is written.
- cpu_rdata holds its value until the next response.

Test Plan:
- Read with slave 1 at base 32'h40000000, mask 32'hc0000000, ready tied high, read_data 32'hdeadbeef, cpu_addr 32'h40000010 -> slv_cs=8'b00000010 at t+1, slv_address=32'h40000010, cpu_ready and cpu_rdata=32'hdeadbeef at t+2.
- Write 32'h12345678 with wstrb 4'b0011, slave ready after 3 wait cycles -> slv_we=4'b0011 and slv_write_data stable for 4 cs cycles, cpu_ready at t+5 for one cycle only.
- Slave 2 never ready, TIMEOUT_CYCLES=4 -> cs high for 4 cycles, cpu_ready at t+5 with rdata=ERROR_RDATA, err_timeout=1, err_addr=request address.
- Access to 32'h80000000 (no hit) -> no cs, cpu_ready at t+1 with rdata 0, err_unmapped=1; err_clear pulse -> flag 0 next cycle; err_clear coincident with a new error -> flag stays 1.
- FW_ONLY slave accessed with fw_app_mode=1 -> no cs, err_violation=1; same access with fw_app_mode=0 -> normal read. force_trap=1 on a mapped access -> ERROR_RDATA at t+1, no flags set.
- Reset asserted during ACCESS -> slv_cs, cpu_ready and all flags 0 asynchronously; after release the next request completes normally.
